// File: rtl/icache_resp_if.sv
// Bundles the fetch-side icache handshake, the backing-memory read port,
// the flush strobe and the performance counters of icache_resp.
interface icache_resp_if;
    logic        icache_rd_i;
    logic [15:0] icache_pc_i;
    logic        icache_valid_o;
    logic [15:0] icache_instr_o;
    logic        icache_busy_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic        mem_ready_i;
    logic [15:0] mem_rdata_i;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;

    // The cache itself
    modport slave (
        input  icache_rd_i, icache_pc_i, flush_i, mem_ready_i, mem_rdata_i,
        output icache_valid_o, icache_instr_o, icache_busy_o,
               mem_req_o, mem_addr_o, hit_cnt_o, miss_cnt_o
    );

    // Fetch stage plus backing memory, seen from the other side
    modport master (
        output icache_rd_i, icache_pc_i, flush_i, mem_ready_i, mem_rdata_i,
        input  icache_valid_o, icache_instr_o, icache_busy_o,
               mem_req_o, mem_addr_o, hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/icache_resp.sv
// Direct-mapped instruction cache responder. Hits answer one cycle after
// the request; misses refill the whole line word by word from the backing
// memory, then answer from the freshly filled line.
module icache_resp #(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    icache_resp_if.slave bus
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 15 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [TAG_W-1:0] tag_q  [LINES];
    logic [15:0]      data_q [LINES][WORDS];
    logic [LINES-1:0] line_valid_q;

    logic [14:0]      req_waddr_q;
    logic [OFF_W-1:0] beat_q;
    logic             flushed_q;
    logic             resp_valid_q;
    logic [15:0]      resp_instr_q;
    logic [15:0]      hit_cnt_q;
    logic [15:0]      miss_cnt_q;

    logic [14:0]      pc_w;
    logic [OFF_W-1:0] in_off;
    logic [IDX_W-1:0] in_idx;
    logic [TAG_W-1:0] in_tag;
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_pc_lsb;

    logic hit;
    logic accept_hit;
    logic accept_miss;
    logic beat_done;
    logic last_beat;

    // Instructions are halfword aligned, so the byte-select bit carries no information
    assign unused_pc_lsb = bus.icache_pc_i[0];

    assign pc_w    = bus.icache_pc_i[15:1];
    assign in_off  = pc_w[OFF_W-1:0];
    assign in_idx  = pc_w[OFF_W +: IDX_W];
    assign in_tag  = pc_w[14 -: TAG_W];
    assign req_off = req_waddr_q[OFF_W-1:0];
    assign req_idx = req_waddr_q[OFF_W +: IDX_W];
    assign req_tag = req_waddr_q[14 -: TAG_W];

    // A flush in the same cycle forces the request down the miss path
    assign hit = line_valid_q[in_idx] && (tag_q[in_idx] == in_tag) && !bus.flush_i;

    // State register; reset drops out of REFILL at once so mem_req_o falls asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and per-cycle event decode
    always_comb begin
        state_d     = state_q;
        accept_hit  = 1'b0;
        accept_miss = 1'b0;
        beat_done   = 1'b0;
        last_beat   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.icache_rd_i) begin
                    if (hit) begin
                        accept_hit = 1'b1;
                    end else begin
                        accept_miss = 1'b1;
                        state_d     = REFILL;
                    end
                end
            end
            REFILL: begin
                if (bus.mem_ready_i) begin
                    beat_done = 1'b1;
                    if (beat_q == OFF_W'(WORDS - 1)) begin
                        last_beat = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_req_o      = (state_q == REFILL);
    assign bus.mem_addr_o     = (state_q == REFILL) ? {req_waddr_q[14:OFF_W], beat_q, 1'b0} : 16'h0000;
    assign bus.icache_busy_o  = (state_q != IDLE);
    assign bus.icache_valid_o = resp_valid_q;
    assign bus.icache_instr_o = resp_instr_q;
    assign bus.hit_cnt_o      = hit_cnt_q;
    assign bus.miss_cnt_o     = miss_cnt_q;

    // Miss bookkeeping: latched word address, beat pointer and a sticky flush-seen flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_waddr_q <= '0;
            beat_q      <= '0;
            flushed_q   <= 1'b0;
        end else begin
            if (accept_miss) begin
                req_waddr_q <= pc_w;
                beat_q      <= '0;
                flushed_q   <= 1'b0;
            end else begin
                if (beat_done) beat_q <= beat_q + OFF_W'(1);
                if ((state_q == REFILL) && bus.flush_i) flushed_q <= 1'b1;
            end
        end
    end

    // Valid bits: flush wipes all; a line only becomes valid if no flush hit its refill
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_valid_q <= '0;
        end else if (bus.flush_i) begin
            line_valid_q <= '0;
        end else begin
            if (accept_miss)              line_valid_q[in_idx]  <= 1'b0;
            if (last_beat && !flushed_q)  line_valid_q[req_idx] <= 1'b1;
        end
    end

    // Tag and data storage need no reset; the valid bits guard them
    always_ff @(posedge clk_i) begin
        if (beat_done) data_q[req_idx][beat_q] <= bus.mem_rdata_i;
        if (last_beat) tag_q[req_idx]          <= req_tag;
    end

    // Response register: single-cycle valid pulse, instruction held until next response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_instr_q <= 16'h0000;
        end else begin
            resp_valid_q <= accept_hit | last_beat;
            if (accept_hit) begin
                resp_instr_q <= data_q[in_idx][in_off];
            end else if (last_beat) begin
                resp_instr_q <= (req_off == beat_q) ? bus.mem_rdata_i : data_q[req_idx][req_off];
            end
        end
    end

    // Saturating hit/miss counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else begin
            if (accept_hit && (hit_cnt_q != 16'hFFFF))   hit_cnt_q  <= hit_cnt_q + 16'd1;
            if (accept_miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_icache_resp.sv
// Directed bench for icache_resp: a word-wide memory model with a
// programmable stall answers refills; each scenario task checks its own results.
module tb_icache_resp;

    logic clk;
    logic rst;

    icache_resp_if bus ();

    icache_resp #(.LINES(8), .WORDS(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    int          stall = 0;
    int          wait_cnt = 0;
    int          req_cycles = 0;
    int          unstable = 0;
    logic [15:0] last_addr = 16'h0000;
    logic [15:0] addr_log[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word k holds k ^ 16'hA5A5
    function automatic logic [15:0] mem_word(input logic [15:0] byte_addr);
        return {1'b0, byte_addr[15:1]} ^ 16'hA5A5;
    endfunction

    // Backing memory: answers after 'stall' waiting cycles per beat
    initial begin
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_req_o) begin
                req_cycles++;
                if (wait_cnt > 0 && bus.mem_addr_o != last_addr) unstable++;
                last_addr = bus.mem_addr_o;
                if (wait_cnt >= stall) begin
                    bus.mem_ready_i = 1'b1;
                    bus.mem_rdata_i = mem_word(bus.mem_addr_o);
                    addr_log.push_back(bus.mem_addr_o);
                    wait_cnt = 0;
                end else begin
                    bus.mem_ready_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ready_i = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Issues one read at a negedge and watches the response window
    task automatic do_read(input logic [15:0] pc, input logic with_flush, input int flush_at,
                           input logic poke, output int pulses, output int latency,
                           output logic [15:0] instr, output int busy_low);
        addr_log.delete();
        req_cycles = 0;
        unstable = 0;
        bus.icache_rd_i = 1'b1;
        bus.icache_pc_i = pc;
        bus.flush_i = with_flush;
        @(negedge clk);
        bus.icache_rd_i = 1'b0;
        bus.flush_i = 1'b0;
        pulses = 0;
        latency = -1;
        instr = 16'hxxxx;
        busy_low = 0;
        for (int c = 1; c <= 200; c++) begin
            if (bus.icache_valid_o) begin
                pulses++;
                if (latency < 0) begin
                    latency = c;
                    instr = bus.icache_instr_o;
                end
            end else if (latency < 0 && !bus.icache_busy_o) begin
                busy_low++;
            end
            if (latency >= 0 && c >= latency + 2) break;
            bus.flush_i = (c == flush_at);
            bus.icache_rd_i = poke && bus.icache_busy_o;
            @(negedge clk);
        end
        bus.icache_rd_i = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.icache_rd_i = 1'b0;
        bus.icache_pc_i = 16'h0000;
        bus.flush_i = 1'b0;
        repeat (2) @(negedge clk);
        n_compared++;
        if (bus.icache_valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.icache_valid_o); end
        n_compared++;
        if (bus.mem_req_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_mem_req: got %b expected 0", bus.mem_req_o); end
        rst = 1'b0;
        @(negedge clk);
        n_compared++;
        if (bus.icache_instr_o !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL reset_instr: got %h expected 0000", bus.icache_instr_o); end
        n_compared++;
        if (bus.mem_addr_o !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", bus.mem_addr_o); end
        n_compared++;
        if (bus.icache_busy_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.icache_busy_o); end
        n_compared++;
        if ({bus.hit_cnt_o, bus.miss_cnt_o} !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_counters: got %h/%h expected 0000/0000", bus.hit_cnt_o, bus.miss_cnt_o); end
    endtask

    task automatic test_miss_refill();
        int p, lat, bl;
        logic [15:0] ins, a;
        stall = 0;
        do_read(16'h0000, 1'b0, 0, 1'b0, p, lat, ins, bl);
        n_compared++;
        if (p !== 1 || lat !== 5) begin n_mismatched++; $display("[TB] FAIL miss_pulse: got pulses=%0d latency=%0d expected 1/5", p, lat); end
        n_compared++;
        if (ins !== 16'hA5A5) begin n_mismatched++; $display("[TB] FAIL miss_instr: got %h expected a5a5", ins); end
        for (int i = 0; i < 4; i++) begin
            a = (i < addr_log.size()) ? addr_log[i] : 16'hxxxx;
            n_compared++;
            if (a !== 16'(2 * i)) begin n_mismatched++; $display("[TB] FAIL miss_addr%0d: got %h expected %h", i, a, 16'(2 * i)); end
        end
        n_compared++;
        if (bus.miss_cnt_o !== 16'd1 || bus.hit_cnt_o !== 16'd0) begin n_mismatched++; $display("[TB] FAIL miss_counters: got %0d/%0d expected hit 0 miss 1", bus.hit_cnt_o, bus.miss_cnt_o); end
    endtask

    task automatic test_hit();
        int p, lat, bl;
        logic [15:0] ins;
        do_read(16'h0004, 1'b0, 0, 1'b0, p, lat, ins, bl);
        n_compared++;
        if (p !== 1 || lat !== 1) begin n_mismatched++; $display("[TB] FAIL hit_pulse: got pulses=%0d latency=%0d expected 1/1", p, lat); end
        n_compared++;
        if (ins !== 16'hA5A7) begin n_mismatched++; $display("[TB] FAIL hit_instr: got %h expected a5a7", ins); end
        n_compared++;
        if (req_cycles !== 0) begin n_mismatched++; $display("[TB] FAIL hit_no_mem_req: got %0d request cycles expected 0", req_cycles); end
        n_compared++;
        if (bus.hit_cnt_o !== 16'd1) begin n_mismatched++; $display("[TB] FAIL hit_count: got %0d expected 1", bus.hit_cnt_o); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pcs [3];
        pcs[0] = 16'h0000;
        pcs[1] = 16'h0002;
        pcs[2] = 16'h0006;
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                n_compared++;
                if (bus.icache_valid_o !== 1'b1 || bus.icache_instr_o !== mem_word(pcs[i-1])) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_resp%0d: got valid=%b instr=%h expected 1/%h", i - 1, bus.icache_valid_o, bus.icache_instr_o, mem_word(pcs[i-1]));
                end
            end
            bus.icache_rd_i = (i < 3);
            if (i < 3) bus.icache_pc_i = pcs[i];
            @(negedge clk);
        end
        n_compared++;
        if (bus.icache_valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_tail: got valid=%b expected 0", bus.icache_valid_o); end
        n_compared++;
        if (bus.hit_cnt_o !== 16'd4) begin n_mismatched++; $display("[TB] FAIL b2b_hits: got %0d expected 4", bus.hit_cnt_o); end
    endtask

    task automatic test_conflict();
        int p, lat, bl;
        logic [15:0] ins, a;
        do_read(16'h0040, 1'b0, 0, 1'b0, p, lat, ins, bl);
        n_compared++;
        if (p !== 1 || ins !== 16'hA585) begin n_mismatched++; $display("[TB] FAIL conflict_resp: got pulses=%0d instr=%h expected 1/a585", p, ins); end
        for (int i = 0; i < 4; i++) begin
            a = (i < addr_log.size()) ? addr_log[i] : 16'hxxxx;
            n_compared++;
            if (a !== 16'(16'h0040 + 2 * i)) begin n_mismatched++; $display("[TB] FAIL conflict_addr%0d: got %h expected %h", i, a, 16'(16'h0040 + 2 * i)); end
        end
        do_read(16'h0000, 1'b0, 0, 1'b0, p, lat, ins, bl);
        n_compared++;
        if (lat !== 5 || ins !== 16'hA5A5) begin n_mismatched++; $display("[TB] FAIL conflict_reread: got latency=%0d instr=%h expected 5/a5a5", lat, ins); end
        n_compared++;
        if (bus.miss_cnt_o !== 16'd3 || bus.hit_cnt_o !== 16'd4) begin n_mismatched++; $display("[TB] FAIL conflict_counters: got hit %0d miss %0d expected 4/3", bus.hit_cnt_o, bus.miss_cnt_o); end
    endtask

    task automatic test_stall();
        int p, lat, bl;
        logic [15:0] ins;
        stall = 3;
        do_read(16'h0012, 1'b0, 0, 1'b1, p, lat, ins, bl);
        stall = 0;
        n_compared++;
        if (p !== 1 || lat !== 17) begin n_mismatched++; $display("[TB] FAIL stall_pulse: got pulses=%0d latency=%0d expected 1/17", p, lat); end
        n_compared++;
        if (ins !== 16'hA5AC) begin n_mismatched++; $display("[TB] FAIL stall_instr: got %h expected a5ac", ins); end
        n_compared++;
        if (unstable !== 0) begin n_mismatched++; $display("[TB] FAIL stall_addr_stable: got %0d changes expected 0", unstable); end
        n_compared++;
        if (bl !== 0) begin n_mismatched++; $display("[TB] FAIL stall_busy: got %0d idle cycles expected 0", bl); end
        n_compared++;
        if (addr_log.size() !== 4 || req_cycles !== 16) begin n_mismatched++; $display("[TB] FAIL stall_beats: got %0d beats %0d req cycles expected 4/16", addr_log.size(), req_cycles); end
        n_compared++;
        if (bus.miss_cnt_o !== 16'd4 || bus.hit_cnt_o !== 16'd4) begin n_mismatched++; $display("[TB] FAIL stall_counters: got hit %0d miss %0d expected 4/4", bus.hit_cnt_o, bus.miss_cnt_o); end
    endtask

    task automatic test_flush_idle();
        int p, lat, bl;
        logic [15:0] ins;
        do_read(16'h0004, 1'b0, 0, 1'b0, p, lat, ins, bl);
        n_compared++;
        if (lat !== 1) begin n_mismatched++; $display("[TB] FAIL preflush_hit: got latency=%0d expected 1", lat); end
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        do_read(16'h0004, 1'b0, 0, 1'b0, p, lat, ins, bl);
        n_compared++;
        if (lat !== 5 || ins !== 16'hA5A7 || addr_log.size() !== 4) begin n_mismatched++; $display("[TB] FAIL flush_idle_miss: got latency=%0d instr=%h beats=%0d expected 5/a5a7/4", lat, ins, addr_log.size()); end
        do_read(16'h0006, 1'b1, 0, 1'b0, p, lat, ins, bl);
        n_compared++;
        if (lat !== 5 || ins !== 16'hA5A6) begin n_mismatched++; $display("[TB] FAIL flush_same_cycle: got latency=%0d instr=%h expected 5/a5a6", lat, ins); end
        n_compared++;
        if (bus.miss_cnt_o !== 16'd6 || bus.hit_cnt_o !== 16'd5) begin n_mismatched++; $display("[TB] FAIL flush_idle_counters: got hit %0d miss %0d expected 5/6", bus.hit_cnt_o, bus.miss_cnt_o); end
    endtask

    task automatic test_flush_refill();
        int p, lat, bl;
        logic [15:0] ins;
        do_read(16'h0012, 1'b0, 2, 1'b0, p, lat, ins, bl);
        n_compared++;
        if (p !== 1 || lat !== 5 || ins !== 16'hA5AC) begin n_mismatched++; $display("[TB] FAIL flush_refill_resp: got pulses=%0d latency=%0d instr=%h expected 1/5/a5ac", p, lat, ins); end
        do_read(16'h0012, 1'b0, 0, 1'b0, p, lat, ins, bl);
        n_compared++;
        if (lat !== 5 || ins !== 16'hA5AC) begin n_mismatched++; $display("[TB] FAIL flush_refill_remiss: got latency=%0d instr=%h expected 5/a5ac", lat, ins); end
        do_read(16'h0012, 1'b0, 0, 1'b0, p, lat, ins, bl);
        n_compared++;
        if (lat !== 1 || ins !== 16'hA5AC) begin n_mismatched++; $display("[TB] FAIL flush_refill_rehit: got latency=%0d instr=%h expected 1/a5ac", lat, ins); end
        n_compared++;
        if (bus.miss_cnt_o !== 16'd8 || bus.hit_cnt_o !== 16'd6) begin n_mismatched++; $display("[TB] FAIL flush_refill_counters: got hit %0d miss %0d expected 6/8", bus.hit_cnt_o, bus.miss_cnt_o); end
    endtask

    task automatic test_reset_midrefill();
        int p, lat, bl;
        logic [15:0] ins;
        stall = 3;
        bus.icache_rd_i = 1'b1;
        bus.icache_pc_i = 16'h0020;
        @(negedge clk);
        bus.icache_rd_i = 1'b0;
        @(negedge clk);
        n_compared++;
        if (bus.mem_req_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midrefill_req: got %b expected 1", bus.mem_req_o); end
        #2 rst = 1'b1;
        #1;
        n_compared++;
        if (bus.mem_req_o !== 1'b0 || bus.icache_busy_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_reset_req: got req=%b busy=%b expected 0/0", bus.mem_req_o, bus.icache_busy_o); end
        n_compared++;
        if ({bus.hit_cnt_o, bus.miss_cnt_o} !== 32'h0) begin n_mismatched++; $display("[TB] FAIL async_reset_counters: got %h/%h expected 0000/0000", bus.hit_cnt_o, bus.miss_cnt_o); end
        @(negedge clk);
        rst = 1'b0;
        stall = 0;
        @(negedge clk);
        do_read(16'h0020, 1'b0, 0, 1'b0, p, lat, ins, bl);
        n_compared++;
        if (p !== 1 || lat !== 5 || ins !== 16'hA5B5) begin n_mismatched++; $display("[TB] FAIL postreset_miss: got pulses=%0d latency=%0d instr=%h expected 1/5/a5b5", p, lat, ins); end
        n_compared++;
        if (bus.miss_cnt_o !== 16'd1 || bus.hit_cnt_o !== 16'd0) begin n_mismatched++; $display("[TB] FAIL postreset_counters: got hit %0d miss %0d expected 0/1", bus.hit_cnt_o, bus.miss_cnt_o); end
    endtask

    initial begin
        $display("[TB] icache_resp directed bench starting");
        test_reset();
        test_miss_refill();
        test_hit();
        test_back_to_back();
        test_conflict();
        test_stall();
        test_flush_idle();
        test_flush_refill();
        test_reset_midrefill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
